riscv_alu_issue: RTL and testbench
==================================

Name: riscv_alu_issue

Overview:
- Issue/writeback stage that drives riscv_alu: accepts 32-bit R-type instructions on a valid/ready handshake and decodes funct3/funct7 into the 4-bit ALU op.
- Reads operands from an internal 32x32 register file and presents registered inA/inB/op to the ALU.
- Captures the ALU result one cycle later and writes it back. It sits between instruction fetch and the ALU.

Parameters:
- WIDTH, 32, data/register width.
- OP_WIDTH, 4, ALU op width.
- NREGS, 32, register file depth (x0 hardwired to 0).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- instr_valid  input  1  instruction present.
- instr_ready  output  1  stage can accept an instruction.
- instr  input  32  RV32 instruction word.
- alu_a  output  WIDTH  ALU operand A (registered rs1 value).
- alu_b  output  WIDTH  ALU operand B (registered rs2 value).
- alu_op  output  OP_WIDTH  ALU op (registered).
- alu_result  input  WIDTH  combinational result returned from ALU.
- wb_valid  output  1  one-cycle pulse: register written.
- wb_rd  output  5  destination written.
- wb_data  output  WIDTH  value written.
- illegal  output  1  one-cycle pulse: rejected instruction.
- dbg_addr  input  5  debug register read address.
- dbg_data  output  WIDTH  combinational regfile read (x0 reads 0).

Behaviour:
- Reset (rst_n=0 at an edge):
  - instr_ready=0, alu_a=0, alu_b=0, alu_op=4'b1111, wb_valid=0, wb_rd=0, wb_data=0, illegal=0.
  - Pipeline valid flag cleared; FSM to CLEAR with counter=0.
  - Reset mid-operation discards any in-flight instruction: no wb_valid, no illegal.
- FSM CLEAR:
  - Writes 0 to register[counter] each cycle; counter 0..NREGS-1.
  - After writing NREGS-1, moves to RUN. NREGS cycles total.
  - instr_ready=0 throughout.
- FSM RUN: instr_ready=1. Accept occurs on an edge where instr_valid && instr_ready.
- Decode is legal only when opcode=7'b0110011 and {funct7,funct3} is one of:
  - 0000000/000 -> 4'b0000 (add)
  - 0100000/000 -> 4'b0001 (sub)
  - 0000000/010 -> 4'b0100 (slt)
  - 0000000/100 -> 4'b1000 (xor)
  - 0000000/110 -> 4'b1100 (or)
  - 0000000/111 -> 4'b1110 (and)
  - Everything else is illegal.
- Legal accept at edge k:
  - alu_a/alu_b/alu_op, ex_rd and ex_valid are loaded at edge k and held through the following cycle.
  - At edge k+1: regfile[ex_rd] <= alu_result (skipped if rd=0), wb_valid=1, wb_rd=ex_rd, wb_data=alu_result. wb_valid drops after one cycle unless another write follows.
  - wb_data for rd=0 still reports alu_result, but x0 stays 0.
- Illegal accept at edge k:
  - illegal=1 for one cycle after edge k.
  - alu_op loaded with 4'b1111; ex_valid=0; no writeback.
- No accept at an edge: ex_valid=0 and alu_op=4'b1111. alu_a/alu_b hold.
- Throughput: one instruction per cycle; no stalls in RUN.
- Operand read:
  - Combinational from regfile in the accept cycle.
  - Bypass: if ex_valid && ex_rd!=0 && ex_rd==rs1 (resp. rs2), use alu_result instead of the regfile value.
  - An instruction accepted two or more edges after the producer reads the regfile directly, since the write has already completed.
  - rs=0 always reads 0, even if ex_rd=0.
- Debug port:
  - dbg_data reflects regfile contents combinationally; no bypass.
  - Valid in CLEAR (partially cleared contents).

Test Plan:
- Reset, then 32 idle cycles -> instr_ready=0 for exactly NREGS cycles after reset release, then 1; dbg_data=0 for all 32 addresses.
- add x1,x0,x0 with ALU model, then sub x2,x1,x1 back-to-back, plus a preload via an or-sequence -> wb_valid pulses on consecutive cycles; wb_rd=1 then 2; values match model.
- Forwarding chain (model ALU): x3 built to 0x00000005 via add; then add x4,x3,x3 issued on the very next cycle -> alu_a=alu_b=5 via bypass; wb_data=0x0000000A; dbg x4=0xA.
- Illegal instr 0x00001033 (sll) and opcode 0x13 (addi) -> illegal=1 one cycle each; alu_op=4'b1111; no wb_valid; regfile unchanged.
- Write to x0 (add x0,x5,x5 with x5=7) -> wb_valid=1, wb_rd=0, wb_data=14; dbg x0 reads 0; a following add x6,x0,x0 gives alu_a=alu_b=0 (no bypass on x0).
- rst_n low for one edge while an instruction sits in the EX slot -> no wb_valid after reset; CLEAR reruns 32 cycles; all registers read 0.

Source files
------------

// File: rtl/riscv_alu_issue.sv
// rtl/riscv_alu_issue.sv - R-type issue/writeback stage with regfile, bypass and clear-on-reset FSM
module riscv_alu_issue #(
    parameter int WIDTH    = 32,
    parameter int OP_WIDTH = 4,
    parameter int NREGS    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [31:0]         instr,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic [OP_WIDTH-1:0] alu_op,
    input  logic [WIDTH-1:0]    alu_result,
    output logic                wb_valid,
    output logic [4:0]          wb_rd,
    output logic [WIDTH-1:0]    wb_data,
    output logic                illegal,
    input  logic [4:0]          dbg_addr,
    output logic [WIDTH-1:0]    dbg_data
);

    localparam logic [6:0]          OPC_R   = 7'b0110011;
    localparam logic [OP_WIDTH-1:0] OP_NONE = {OP_WIDTH{1'b1}};

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t               state_q, state_d;
    logic [4:0]           cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic [WIDTH-1:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [OP_WIDTH-1:0]  alu_op_q, alu_op_d;
    logic                 ex_valid_q, ex_valid_d;
    logic [4:0]           ex_rd_q, ex_rd_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [4:0]           wb_rd_q, wb_rd_d;
    logic [WIDTH-1:0]     wb_data_q, wb_data_d;
    logic                 illegal_q, illegal_d;

    logic [WIDTH-1:0]     regs_q [NREGS];
    logic                 rf_we;
    logic [4:0]           rf_waddr;
    logic [WIDTH-1:0]     rf_wdata;

    logic [6:0]           opcode, funct7;
    logic [2:0]           funct3;
    logic [4:0]           rd, rs1, rs2;
    logic                 dec_legal;
    logic [OP_WIDTH-1:0]  dec_op;
    logic [WIDTH-1:0]     rs1_val, rs2_val;
    logic                 accept;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];
    assign accept = instr_valid && ready_q;

    always_comb begin
        dec_legal = 1'b0;
        dec_op    = OP_NONE;
        if (opcode == OPC_R) begin
            case ({funct7, funct3})
                10'b0000000_000: begin dec_legal = 1'b1; dec_op = OP_WIDTH'(4'b0000); end
                10'b0100000_000: begin dec_legal = 1'b1; dec_op = OP_WIDTH'(4'b0001); end
                10'b0000000_010: begin dec_legal = 1'b1; dec_op = OP_WIDTH'(4'b0100); end
                10'b0000000_100: begin dec_legal = 1'b1; dec_op = OP_WIDTH'(4'b1000); end
                10'b0000000_110: begin dec_legal = 1'b1; dec_op = OP_WIDTH'(4'b1100); end
                10'b0000000_111: begin dec_legal = 1'b1; dec_op = OP_WIDTH'(4'b1110); end
                default: ;
            endcase
        end
    end

    // The instruction in EX writes back on the same edge this one issues, so forward its result.
    always_comb begin
        if (rs1 == 5'd0)
            rs1_val = '0;
        else if (ex_valid_q && ex_rd_q == rs1)
            rs1_val = alu_result;
        else
            rs1_val = regs_q[rs1];

        if (rs2 == 5'd0)
            rs2_val = '0;
        else if (ex_valid_q && ex_rd_q == rs2)
            rs2_val = alu_result;
        else
            rs2_val = regs_q[rs2];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ready_d    = ready_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = OP_NONE;
        ex_valid_d = 1'b0;
        ex_rd_d    = ex_rd_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        illegal_d  = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = ex_rd_q;
        rf_wdata   = alu_result;

        if (state_q == S_CLEAR) begin
            rf_we    = 1'b1;
            rf_waddr = cnt_q;
            rf_wdata = '0;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'(NREGS - 1)) begin
                state_d = S_RUN;
                ready_d = 1'b1;
            end
        end else begin
            ready_d = 1'b1;
            if (ex_valid_q) begin
                wb_valid_d = 1'b1;
                wb_rd_d    = ex_rd_q;
                wb_data_d  = alu_result;
                rf_we      = (ex_rd_q != 5'd0);
            end
            if (accept) begin
                if (dec_legal) begin
                    alu_a_d    = rs1_val;
                    alu_b_d    = rs2_val;
                    alu_op_d   = dec_op;
                    ex_valid_d = 1'b1;
                    ex_rd_d    = rd;
                end else begin
                    illegal_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_CLEAR;
            cnt_q      <= 5'd0;
            ready_q    <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= OP_NONE;
            ex_valid_q <= 1'b0;
            ex_rd_q    <= 5'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            ex_valid_q <= ex_valid_d;
            ex_rd_q    <= ex_rd_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            illegal_q  <= illegal_d;
        end
    end

    // Gated by rst_n so a reset landing on a writeback edge drops the in-flight result.
    always_ff @(posedge clk) begin
        if (rst_n && rf_we)
            regs_q[rf_waddr] <= rf_wdata;
    end

    assign instr_ready = ready_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign illegal     = illegal_q;
    assign dbg_data    = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_riscv_alu_issue.sv
// tb/tb_riscv_alu_issue.sv - self-checking bench for riscv_alu_issue against a sequential ISA model
module tb_riscv_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    logic        ov_en;
    logic [31:0] ov_val;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ref_rf [32];
    logic        pend_v;
    logic [4:0]  pend_rd;
    logic [31:0] pend_data;
    logic [31:0] exp_a, exp_b;

    typedef struct {
        logic [31:0] ins;
        logic        ill;
        logic [3:0]  op;
    } vec_t;
    vec_t tbl [11];

    always #50 clk = ~clk;

    riscv_alu_issue #(.WIDTH(32), .OP_WIDTH(4), .NREGS(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .illegal(illegal),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: return a ^ b;
            4'b1100: return a | b;
            4'b1110: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    always_comb alu_result = ov_en ? ov_val : alu_fn(alu_op, alu_a, alu_b);

    function automatic logic [4:0] ref_decode(input logic [31:0] ins);
        if (ins[6:0] != 7'h33) return 5'b0_1111;
        case ({ins[31:25], ins[14:12]})
            10'b0000000_000: return 5'b1_0000;
            10'b0100000_000: return 5'b1_0001;
            10'b0000000_010: return 5'b1_0100;
            10'b0000000_100: return 5'b1_1000;
            10'b0000000_110: return 5'b1_1100;
            10'b0000000_111: return 5'b1_1110;
            default:         return 5'b0_1111;
        endcase
    endfunction

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
        pend_v = 1'b0;
        pend_rd = 5'd0;
        pend_data = 32'd0;
        exp_a = 32'd0;
        exp_b = 32'd0;
    endtask

    task automatic dbg_all(input string nm);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            chk(nm, dbg_data, ref_rf[i]);
        end
    endtask

    // One clock edge: drive an optional instruction, then check everything against the model.
    task automatic step(input logic v, input logic [31:0] ins, input logic oe, input logic [31:0] ov);
        logic [4:0]  dec;
        logic        lg;
        logic [31:0] a, b;
        instr_valid = v;
        instr = ins;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        chk("wb_valid", wb_valid, pend_v);
        if (pend_v) begin
            chk("wb_rd", wb_rd, pend_rd);
            chk("wb_data", wb_data, pend_data);
            if (pend_rd != 5'd0) ref_rf[pend_rd] = pend_data;
        end
        dec = ref_decode(ins);
        lg = v && dec[4];
        chk("illegal", illegal, v && !dec[4]);
        chk("alu_op", alu_op, lg ? dec[3:0] : 4'hF);
        if (lg) begin
            a = ref_rf[ins[19:15]];
            b = ref_rf[ins[24:20]];
            exp_a = a;
            exp_b = b;
            pend_v = 1'b1;
            pend_rd = ins[11:7];
            pend_data = oe ? ov : alu_fn(dec[3:0], a, b);
        end else begin
            pend_v = 1'b0;
        end
        chk("alu_a", alu_a, exp_a);
        chk("alu_b", alu_b, exp_b);
        chk("instr_ready", instr_ready, 1'b1);
        ov_en = oe && lg;
        ov_val = ov;
        dbg_addr = 5'($urandom_range(0, 31));
        #1;
        chk("dbg_rand", dbg_data, ref_rf[dbg_addr]);
    endtask

    task automatic preload(input logic [4:0] rd, input logic [31:0] val);
        step(1'b1, rtype(7'h00, 5'd0, 5'd0, 3'b000, rd), 1'b1, val);
    endtask

    task automatic do_reset(input int hold);
        int n;
        rst_n = 1'b0;
        instr_valid = 1'b0;
        ov_en = 1'b0;
        repeat (hold) @(posedge clk);
        #1;
        chk("rst_ready", instr_ready, 1'b0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_op", alu_op, 4'hF);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_rd", wb_rd, 5'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_illegal", illegal, 1'b0);
        model_reset();
        rst_n = 1'b1;
        n = 0;
        while (instr_ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (wb_valid !== 1'b0 || illegal !== 1'b0) chk("clear_quiet", {wb_valid, illegal}, 2'b00);
        end
        chk("clear_cycles", n, 32'd32);
        dbg_all("dbg_cleared");
    endtask

    initial begin
        logic [31:0] ins;
        logic [9:0]  ff;
        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr = 32'd0;
        dbg_addr = 5'd0;
        ov_en = 1'b0;
        ov_val = 32'd0;
        model_reset();

        tbl[0]  = '{rtype(7'h00, 5'd3, 5'd2, 3'b000, 5'd1), 1'b0, 4'b0000};
        tbl[1]  = '{rtype(7'h20, 5'd3, 5'd2, 3'b000, 5'd1), 1'b0, 4'b0001};
        tbl[2]  = '{rtype(7'h00, 5'd3, 5'd2, 3'b010, 5'd1), 1'b0, 4'b0100};
        tbl[3]  = '{rtype(7'h00, 5'd3, 5'd2, 3'b100, 5'd1), 1'b0, 4'b1000};
        tbl[4]  = '{rtype(7'h00, 5'd3, 5'd2, 3'b110, 5'd1), 1'b0, 4'b1100};
        tbl[5]  = '{rtype(7'h00, 5'd3, 5'd2, 3'b111, 5'd1), 1'b0, 4'b1110};
        tbl[6]  = '{rtype(7'h00, 5'd3, 5'd2, 3'b001, 5'd1), 1'b1, 4'b1111};
        tbl[7]  = '{rtype(7'h20, 5'd3, 5'd2, 3'b010, 5'd1), 1'b1, 4'b1111};
        tbl[8]  = '{rtype(7'h01, 5'd3, 5'd2, 3'b000, 5'd1), 1'b1, 4'b1111};
        tbl[9]  = '{32'h00000013, 1'b1, 4'b1111};
        tbl[10] = '{32'h002081B7, 1'b1, 4'b1111};

        do_reset(3);

        for (int i = 0; i < 11; i++) begin
            step(1'b1, tbl[i].ins, 1'b0, 32'd0);
            chk("tbl_op", alu_op, tbl[i].op);
            chk("tbl_illegal", illegal, tbl[i].ill);
        end
        step(1'b0, 32'd0, 1'b0, 32'd0);

        preload(5'd8, 32'h0000_1234);
        step(1'b1, rtype(7'h00, 5'd0, 5'd0, 3'b000, 5'd1), 1'b0, 32'd0);
        step(1'b1, rtype(7'h20, 5'd1, 5'd1, 3'b000, 5'd2), 1'b0, 32'd0);
        chk("seq_wb_rd1", wb_rd, 5'd1);
        step(1'b1, rtype(7'h00, 5'd8, 5'd8, 3'b110, 5'd9), 1'b0, 32'd0);
        chk("seq_wb_rd2", wb_rd, 5'd2);
        step(1'b0, 32'd0, 1'b0, 32'd0);
        chk("seq_or_val", wb_data, 32'h0000_1234);

        preload(5'd3, 32'd5);
        step(1'b1, rtype(7'h00, 5'd3, 5'd3, 3'b000, 5'd4), 1'b0, 32'd0);
        chk("fwd_a", alu_a, 32'd5);
        chk("fwd_b", alu_b, 32'd5);
        step(1'b0, 32'd0, 1'b0, 32'd0);
        chk("fwd_wb", wb_data, 32'h0000_000A);
        dbg_addr = 5'd4;
        #1;
        chk("fwd_dbg_x4", dbg_data, 32'h0000_000A);

        step(1'b1, 32'h00001033, 1'b0, 32'd0);
        chk("ill_sll", illegal, 1'b1);
        step(1'b1, 32'h00000013, 1'b0, 32'd0);
        chk("ill_addi", illegal, 1'b1);
        chk("ill_op", alu_op, 4'hF);
        step(1'b0, 32'd0, 1'b0, 32'd0);
        chk("ill_no_wb", wb_valid, 1'b0);
        dbg_all("ill_rf");

        preload(5'd5, 32'd7);
        step(1'b1, rtype(7'h00, 5'd5, 5'd5, 3'b000, 5'd0), 1'b0, 32'd0);
        step(1'b1, rtype(7'h00, 5'd0, 5'd0, 3'b000, 5'd6), 1'b0, 32'd0);
        chk("x0_wb_valid", wb_valid, 1'b1);
        chk("x0_wb_rd", wb_rd, 5'd0);
        chk("x0_wb_data", wb_data, 32'd14);
        chk("x0_nobyp_a", alu_a, 32'd0);
        chk("x0_nobyp_b", alu_b, 32'd0);
        dbg_addr = 5'd0;
        #1;
        chk("x0_dbg", dbg_data, 32'd0);
        step(1'b0, 32'd0, 1'b0, 32'd0);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0: ff = 10'b0000000_000;
                1: ff = 10'b0100000_000;
                2: ff = 10'b0000000_010;
                3: ff = 10'b0000000_100;
                4: ff = 10'b0000000_110;
                default: ff = 10'b0000000_111;
            endcase
            if ($urandom_range(0, 9) < 7)
                ins = rtype(ff[9:3], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                            ff[2:0], 5'($urandom_range(0, 7)));
            else
                ins = $urandom;
            step($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) == 0, $urandom);
        end
        step(1'b0, 32'd0, 1'b0, 32'd0);
        dbg_all("rand_rf");

        preload(5'd7, 32'h0000_0055);
        do_reset(1);
        step(1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b1, rtype(7'h00, 5'd7, 5'd7, 3'b000, 5'd10), 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b0, 32'd0);
        chk("post_rst_x10", wb_data, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
